mux3_to_1_8bit: RTL and testbench

Registered 3-to-1 byte selector in the point-cloud datapath. Each clock it routes one of three 8-bit operands (N, K, M) to a registered output under a one-hot select. It also flags illegal select codes so upstream control errors are visible downstream.

---
 rtl/mux3_to_1_8bit_if.sv | 28 ++
 rtl/mux3_to_1_8bit.sv | 46 ++++
 tb/tb_mux3_to_1_8bit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mux3_to_1_8bit_if.sv
// Operand, select and result bundle for the registered 3-to-1 byte selector.
// The master drives operands and select; the slave returns the registered result.
interface mux3_to_1_8bit_if;
    logic [7:0] mux_inN;
    logic [7:0] mux_inK;
    logic [7:0] mux_inM;
    logic [2:0] mux_sel;
    logic [7:0] mux_out;
    logic       sel_err;

    modport master (
        output mux_inN,
        output mux_inK,
        output mux_inM,
        output mux_sel,
        input  mux_out,
        input  sel_err
    );

    modport slave (
        input  mux_inN,
        input  mux_inK,
        input  mux_inM,
        input  mux_sel,
        output mux_out,
        output sel_err
    );
endinterface

// File: rtl/mux3_to_1_8bit.sv
// Registered one-hot 3-to-1 byte selector for the point-cloud datapath.
// Illegal or unknown select codes yield 8'h00 and raise sel_err.
module mux3_to_1_8bit (
    input  logic              Clk,
    input  logic              rst_n,
    mux3_to_1_8bit_if.slave   bus
);

    logic [7:0] dec_data;
    logic       dec_err;

    // Exact one-hot match only; X/Z on the select falls through to default.
    always_comb begin
        dec_data = 8'h00;
        dec_err  = 1'b1;
        case (bus.mux_sel)
            3'b001: begin
                dec_data = bus.mux_inN;
                dec_err  = 1'b0;
            end
            3'b010: begin
                dec_data = bus.mux_inK;
                dec_err  = 1'b0;
            end
            3'b100: begin
                dec_data = bus.mux_inM;
                dec_err  = 1'b0;
            end
            default: begin
                dec_data = 8'h00;
                dec_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mux_out <= 8'h00;
            bus.sel_err <= 1'b0;
        end else begin
            bus.mux_out <= dec_data;
            bus.sel_err <= dec_err;
        end
    end

endmodule

// File: tb/tb_mux3_to_1_8bit.sv
// Self-checking bench for mux3_to_1_8bit: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_mux3_to_1_8bit;

    logic Clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   cmp_en;
    logic [7:0] exp_out;
    logic       exp_err;

    mux3_to_1_8bit_if bus ();

    mux3_to_1_8bit dut (
        .Clk   (Clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [8:0] ref_f(
        input logic [2:0] s,
        input logic [7:0] n,
        input logic [7:0] k,
        input logic [7:0] m
    );
        logic [7:0] d [3];
        d[0] = n;
        d[1] = k;
        d[2] = m;
        if ($isunknown(s) || $countones(s) != 1)
            return {1'b1, 8'h00};
        for (int i = 0; i < 3; i++)
            if (s[i] === 1'b1)
                return {1'b0, d[i]};
        return {1'b1, 8'h00};
    endfunction

    // Behavioural reference: one-cycle delayed result, cleared by reset.
    initial begin
        exp_out = 8'h00;
        exp_err = 1'b0;
    end
    always @(posedge Clk or negedge rst_n) begin
        logic [8:0] r;
        if (!rst_n) begin
            exp_out = 8'h00;
            exp_err = 1'b0;
        end else begin
            r = ref_f(bus.mux_sel, bus.mux_inN, bus.mux_inK, bus.mux_inM);
            exp_out = r[7:0];
            exp_err = r[8];
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("model_out", bus.mux_out, exp_out);
            chk("model_err", {7'd0, bus.sel_err}, {7'd0, exp_err});
        end
    end

    task automatic drive(input logic [2:0] s, input logic [7:0] n,
                         input logic [7:0] k, input logic [7:0] m);
        @(negedge Clk);
        bus.mux_sel = s;
        bus.mux_inN = n;
        bus.mux_inK = k;
        bus.mux_inM = m;
    endtask

    task automatic edge_chk(input string name, input logic [7:0] eo, input logic ee);
        @(posedge Clk);
        #1;
        chk({name, "_out"}, bus.mux_out, eo);
        chk({name, "_err"}, {7'd0, bus.sel_err}, {7'd0, ee});
    endtask

    logic [2:0] ill [4];

    initial begin
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        rst_n    = 1'b1;
        bus.mux_sel = 3'b001;
        bus.mux_inN = 8'hAA;
        bus.mux_inK = 8'h80;
        bus.mux_inM = 8'h92;
        #1 rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("rst_async_out", bus.mux_out, 8'h00);

        // Reset held with a legal select: outputs stay cleared.
        for (int i = 0; i < 3; i++)
            edge_chk("rst_hold", 8'h00, 1'b0);
        @(negedge Clk);
        rst_n = 1'b1;
        edge_chk("rst_release", 8'hAA, 1'b0);

        drive(3'b001, 8'hAA, 8'h80, 8'h92);
        edge_chk("sel_n", 8'hAA, 1'b0);
        drive(3'b010, 8'hAA, 8'h80, 8'h92);
        edge_chk("sel_k", 8'h80, 1'b0);
        drive(3'b100, 8'hAA, 8'h80, 8'h92);
        edge_chk("sel_m", 8'h92, 1'b0);

        ill[0] = 3'b000;
        ill[1] = 3'b011;
        ill[2] = 3'b110;
        ill[3] = 3'b111;
        for (int i = 0; i < 4; i++) begin
            drive(ill[i], 8'hAA, 8'h80, 8'h92);
            edge_chk("sel_illegal", 8'h00, 1'b1);
        end
        // Unknown select: the model rules on whatever value the DUT sees.
        drive(3'bxxx, 8'hAA, 8'h80, 8'h92);
        @(posedge Clk);
        #1;
        chk("sel_x_known", {7'd0, $isunknown(bus.mux_out)}, 8'h00);

        // Mid-cycle operand change must not leak before the next edge.
        drive(3'b010, 8'hAA, 8'h80, 8'h92);
        edge_chk("hold_pre", 8'h80, 1'b0);
        #2 bus.mux_inK = 8'h3C;
        #1 chk("hold_mid", bus.mux_out, 8'h80);
        edge_chk("hold_post", 8'h3C, 1'b0);

        // Asynchronous reset between edges, then release cleanly.
        drive(3'b100, 8'hAA, 8'h3C, 8'h92);
        edge_chk("arst_pre", 8'h92, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("arst_out", bus.mux_out, 8'h00);
        chk("arst_err", {7'd0, bus.sel_err}, 8'h00);
        @(posedge Clk);
        #1 chk("arst_hold", bus.mux_out, 8'h00);
        @(negedge Clk);
        rst_n = 1'b1;
        bus.mux_sel = 3'b001;
        bus.mux_inN = 8'h5A;
        edge_chk("arst_rel", 8'h5A, 1'b0);

        // Random stress; the negedge compare process checks every cycle.
        for (int i = 0; i < 1000; i++) begin
            logic [2:0] s;
            if ($urandom_range(0, 1) == 0)
                s = 3'($urandom_range(0, 7));
            else
                s = 3'(1 << $urandom_range(0, 2));
            drive(s, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        @(negedge Clk);
        @(negedge Clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
